// File: rtl/arya_dispatch_pkg.sv
// Shared types and default sizing for the Arya thread dispatcher.
// Slot-state encodings plus the default widths derived from the core array shape.
package arya_dispatch_pkg;

    localparam int DEF_NUM_CORES            = 2;
    localparam int DEF_NUM_THREADS_PER_CORE = 4;
    localparam int DEF_JOB_ID_WIDTH         = 8;
    localparam int DEF_QUEUE_DEPTH          = 8;
    localparam int DEF_LAUNCH_TIMEOUT       = 15;

    localparam int DEF_NT     = DEF_NUM_CORES * DEF_NUM_THREADS_PER_CORE;
    localparam int DEF_TID_W  = $clog2(DEF_NT);
    localparam int DEF_QCNT_W = $clog2(DEF_QUEUE_DEPTH) + 1;

    typedef enum logic [2:0] {
        SLOT_IDLE      = 3'd0,
        SLOT_LAUNCH    = 3'd1,
        SLOT_WAIT_BUSY = 3'd2,
        SLOT_RUN       = 3'd3,
        SLOT_REPORT    = 3'd4
    } slot_state_e;

endpackage

// File: rtl/arya_job_fifo.sv
// Synchronous job FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy register.
module arya_job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/arya_thread_dispatcher.sv
// Buffers incoming job IDs, launches each on the lowest free hardware thread,
// watches it through busy/done and reports completions one per cycle.
module arya_thread_dispatcher
    import arya_dispatch_pkg::*;
#(
    parameter int NUM_CORES            = DEF_NUM_CORES,
    parameter int NUM_THREADS_PER_CORE = DEF_NUM_THREADS_PER_CORE,
    parameter int JOB_ID_WIDTH         = DEF_JOB_ID_WIDTH,
    parameter int QUEUE_DEPTH          = DEF_QUEUE_DEPTH,
    parameter int LAUNCH_TIMEOUT       = DEF_LAUNCH_TIMEOUT,
    localparam int NT     = NUM_CORES * NUM_THREADS_PER_CORE,
    localparam int TID_W  = $clog2(NT),
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic                    job_valid_i,
    input  logic [JOB_ID_WIDTH-1:0] job_id_i,
    output logic                    job_ready_o,
    output logic [NT-1:0]           start_thread_o,
    input  logic [NT-1:0]           thread_busy_i,
    input  logic [NT-1:0]           thread_done_i,
    output logic                    done_valid_o,
    output logic [JOB_ID_WIDTH-1:0] done_job_id_o,
    output logic [TID_W-1:0]        done_thread_o,
    output logic [QCNT_W-1:0]       queue_count_o,
    output logic                    launch_error_o,
    output logic [TID_W-1:0]        err_thread_o,
    output logic [NT*3-1:0]         dbg_slot_state_o
);

    // Job port: a transfer happens on a cycle where job_valid_i and job_ready_o are both high.
    localparam int TO_W = $clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(LAUNCH_TIMEOUT);

    slot_state_e             state_q [NT];
    slot_state_e             state_d [NT];
    logic [JOB_ID_WIDTH-1:0] job_q   [NT];
    logic [JOB_ID_WIDTH-1:0] job_d   [NT];
    logic [TO_W-1:0]         cnt_q   [NT];
    logic [TO_W-1:0]         cnt_d   [NT];

    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [JOB_ID_WIDTH-1:0] fifo_head;
    logic                    disp_found, rep_found, err_found, dispatch;
    logic [TID_W-1:0]        disp_idx, rep_idx, err_idx;
    logic [NT-1:0]           timeout_hit;

    logic                    done_valid_q;
    logic [JOB_ID_WIDTH-1:0] done_job_id_q;
    logic [TID_W-1:0]        done_thread_q;
    logic                    launch_error_q;
    logic [TID_W-1:0]        err_thread_q;

    assign job_ready_o = !fifo_full && en_i;
    assign fifo_push   = job_valid_i && job_ready_o;
    assign dispatch    = en_i && !fifo_empty && disp_found;
    assign fifo_pop    = dispatch;

    arya_job_fifo #(
        .WIDTH (JOB_ID_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (job_id_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (queue_count_o)
    );

    // Lowest-index encoders for dispatch target, report source and first timeout.
    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        rep_found  = 1'b0;
        rep_idx    = '0;
        err_found  = 1'b0;
        err_idx    = '0;
        for (int i = 0; i < NT; i++) begin
            if (!disp_found && state_q[i] == SLOT_IDLE) begin
                disp_found = 1'b1;
                disp_idx   = TID_W'(i);
            end
            if (!rep_found && state_q[i] == SLOT_REPORT) begin
                rep_found = 1'b1;
                rep_idx   = TID_W'(i);
            end
            if (!err_found && timeout_hit[i]) begin
                err_found = 1'b1;
                err_idx   = TID_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        job_d          = job_q;
        cnt_d          = cnt_q;
        start_thread_o = '0;
        timeout_hit    = '0;
        for (int i = 0; i < NT; i++) begin
            case (state_q[i])
                SLOT_IDLE: begin
                    if (dispatch && disp_idx == TID_W'(i)) begin
                        state_d[i] = SLOT_LAUNCH;
                        job_d[i]   = fifo_head;
                    end
                end
                SLOT_LAUNCH: begin
                    start_thread_o[i] = 1'b1;
                    state_d[i]        = SLOT_WAIT_BUSY;
                    cnt_d[i]          = '0;
                end
                SLOT_WAIT_BUSY: begin
                    // A busy seen on the last allowed cycle still counts as a launch.
                    if (thread_busy_i[i]) begin
                        state_d[i] = SLOT_RUN;
                    end else if (cnt_q[i] + 1'b1 == TO_LIMIT) begin
                        state_d[i]     = SLOT_IDLE;
                        timeout_hit[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                SLOT_RUN: begin
                    if (thread_done_i[i]) state_d[i] = SLOT_REPORT;
                end
                SLOT_REPORT: begin
                    if (rep_found && rep_idx == TID_W'(i)) state_d[i] = SLOT_IDLE;
                end
                default: state_d[i] = SLOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NT; i++) begin
                state_q[i] <= SLOT_IDLE;
                job_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            done_valid_q   <= 1'b0;
            done_job_id_q  <= '0;
            done_thread_q  <= '0;
            launch_error_q <= 1'b0;
            err_thread_q   <= '0;
        end else begin
            state_q      <= state_d;
            job_q        <= job_d;
            cnt_q        <= cnt_d;
            done_valid_q <= rep_found;
            if (rep_found) begin
                done_job_id_q <= job_q[rep_idx];
                done_thread_q <= rep_idx;
            end
            if (err_found) begin
                launch_error_q <= 1'b1;
                if (!launch_error_q) err_thread_q <= err_idx;
            end
        end
    end

    always_comb begin
        dbg_slot_state_o = '0;
        for (int i = 0; i < NT; i++) begin
            dbg_slot_state_o[i*3 +: 3] = state_q[i];
        end
    end

    assign done_valid_o   = done_valid_q;
    assign done_job_id_o  = done_job_id_q;
    assign done_thread_o  = done_thread_q;
    assign launch_error_o = launch_error_q;
    assign err_thread_o   = err_thread_q;

endmodule

// File: tb/tb_arya_thread_dispatcher.sv
// Bench for arya_thread_dispatcher: directed jobs, a registered core model,
// and expected-queue scoreboards for launches and completion reports.
module tb_arya_thread_dispatcher;

    localparam int NT = 8;
    localparam int JW = 8;
    localparam int TW = 3;
    localparam int QW = 4;
    localparam int LT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          job_valid;
    logic [JW-1:0] job_id;
    logic          job_ready;
    logic [NT-1:0] start_thread;
    logic [NT-1:0] thread_busy;
    logic [NT-1:0] thread_done;
    logic          done_valid;
    logic [JW-1:0] done_job_id;
    logic [TW-1:0] done_thread;
    logic [QW-1:0] queue_count;
    logic          launch_error;
    logic [TW-1:0] err_thread;
    logic [NT*3-1:0] dbg_state;

    always #5 clk = ~clk;

    arya_thread_dispatcher dut (
        .clk              (clk),
        .reset            (reset),
        .en_i             (en),
        .job_valid_i      (job_valid),
        .job_id_i         (job_id),
        .job_ready_o      (job_ready),
        .start_thread_o   (start_thread),
        .thread_busy_i    (thread_busy),
        .thread_done_i    (thread_done),
        .done_valid_o     (done_valid),
        .done_job_id_o    (done_job_id),
        .done_thread_o    (done_thread),
        .queue_count_o    (queue_count),
        .launch_error_o   (launch_error),
        .err_thread_o     (err_thread),
        .dbg_slot_state_o (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    logic [TW-1:0]    launch_exp_q[$];
    logic [TW+JW-1:0] done_exp_q[$];
    logic [JW-1:0]    thr_job [NT];
    logic [NT-1:0]    no_busy = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Core model: busy registered one edge after the launch pulse, cleared by done.
    always @(posedge clk) begin
        if (reset) begin
            thread_busy <= '0;
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (thread_done[i]) thread_busy[i] <= 1'b0;
                else if (start_thread[i] && !no_busy[i]) thread_busy[i] <= 1'b1;
            end
        end
    end

    // Monitor: every launch pulse and every report is checked against the expected queues.
    always @(negedge clk) begin
        logic [TW-1:0]    lexp;
        logic [TW+JW-1:0] dexp;
        if (start_thread !== '0) begin
            if (launch_exp_q.size() == 0) begin
                check("unexpected_launch", 32'(start_thread), 32'd0);
            end else begin
                lexp = launch_exp_q.pop_front();
                check("launch_thread", 32'(start_thread), 32'(NT'(1) << lexp));
            end
        end
        if (done_valid === 1'b1) begin
            if (done_exp_q.size() == 0) begin
                check("unexpected_report", 32'({done_thread, done_job_id}), 32'hFFFF);
            end else begin
                dexp = done_exp_q.pop_front();
                check("report_thread_id", 32'({done_thread, done_job_id}), 32'(dexp));
            end
        end
    end

    task automatic push_job(input logic [JW-1:0] id, output logic ok);
        @(negedge clk);
        job_valid = 1'b1;
        job_id    = id;
        ok        = job_ready;
    endtask

    task automatic stop_push();
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic expect_launch(input int t, input logic [JW-1:0] id);
        launch_exp_q.push_back(TW'(t));
        thr_job[t] = id;
    endtask

    task automatic pulse_done(input logic [NT-1:0] mask);
        for (int i = 0; i < NT; i++) begin
            if (mask[i]) done_exp_q.push_back({TW'(i), thr_job[i]});
        end
        @(negedge clk);
        thread_done = mask;
        @(negedge clk);
        thread_done = '0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int c = 0;
        while ((launch_exp_q.size() != 0 || done_exp_q.size() != 0) && c < maxc) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(name, 32'(launch_exp_q.size() + done_exp_q.size()), 32'd0);
    endtask

    initial begin
        logic ok;
        logic ok_all;
        int   c;
        reset       = 1'b1;
        en          = 1'b1;
        job_valid   = 1'b0;
        job_id      = '0;
        thread_done = '0;
        for (int i = 0; i < NT; i++) thr_job[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_start_thread", 32'(start_thread), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_id_thread", 32'({done_thread, done_job_id}), 32'd0);
        check("rst_launch_error", 32'(launch_error), 32'd0);
        check("rst_err_thread", 32'(err_thread), 32'd0);
        check("rst_queue_count", 32'(queue_count), 32'd0);
        check("rst_job_ready", 32'(job_ready), 32'd1);
        reset = 1'b0;

        // Single job: launch two cycles after accept, report after done.
        expect_launch(0, 8'h2A);
        push_job(8'h2A, ok);
        check("t1_accept", 32'(ok), 32'd1);
        stop_push();
        check("t1_queue_count_after_push", 32'(queue_count), 32'd1);
        check("t1_no_bypass_launch", 32'(start_thread), 32'd0);
        @(negedge clk);
        check("t1_start_pulse", 32'(start_thread), 32'h01);
        check("t1_queue_count_after_pop", 32'(queue_count), 32'd0);
        @(negedge clk);
        check("t1_start_one_cycle", 32'(start_thread), 32'd0);
        repeat (20) @(negedge clk);
        pulse_done(8'h01);
        check("t1_report_not_early", 32'(done_valid), 32'd0);
        wait_drain("t1_drain", 10);

        // Fill all threads and the FIFO.
        for (int k = 0; k < 8; k++) expect_launch(k, JW'(8'h10 + k));
        ok_all = 1'b1;
        for (int k = 0; k < 16; k++) begin
            push_job(JW'(8'h10 + k), ok);
            ok_all = ok_all & ok;
        end
        stop_push();
        check("t2_all_accepted", 32'(ok_all), 32'd1);
        check("t2_queue_full_count", 32'(queue_count), 32'd8);
        check("t2_ready_low_full", 32'(job_ready), 32'd0);
        push_job(8'hEE, ok);
        check("t2_full_push_refused", 32'(ok), 32'd0);
        repeat (3) @(negedge clk);
        check("t2_ready_still_low", 32'(job_ready), 32'd0);
        stop_push();
        check("t2_full_count_held", 32'(queue_count), 32'd8);
        wait_drain("t2_initial_launches", 5);
        pulse_done(8'h08);
        expect_launch(3, 8'h18);
        wait_drain("t2_relaunch_thread3", 20);
        check("t2_queue_after_relaunch", 32'(queue_count), 32'd7);

        // Simultaneous done on threads 1, 5, 6.
        pulse_done(8'b0110_0010);
        expect_launch(1, 8'h19);
        expect_launch(5, 8'h1A);
        expect_launch(6, 8'h1B);
        wait_drain("t3_ordered_reports", 20);
        check("t3_queue_count", 32'(queue_count), 32'd4);

        // Launch timeout on thread 2, then thread 2 is reused.
        no_busy[2] = 1'b1;
        pulse_done(8'h04);
        expect_launch(2, 8'h1C);
        check("t4_no_error_yet", 32'(launch_error), 32'd0);
        c = 0;
        while (launch_error !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        no_busy[2] = 1'b0;
        expect_launch(2, 8'h1D);
        check("t4_launch_error", 32'(launch_error), 32'd1);
        check("t4_err_thread", 32'(err_thread), 32'd2);
        check("t4_timeout_window", 32'(c >= LT && c <= LT + 6), 32'd1);
        wait_drain("t4_thread2_reused", 20);
        check("t4_error_sticky", 32'(launch_error), 32'd1);

        // Enable gating with three queued jobs; in-flight work still reports.
        push_job(8'h20, ok);
        stop_push();
        check("t5_accept", 32'(ok), 32'd1);
        check("t5_three_queued", 32'(queue_count), 32'd3);
        en = 1'b0;
        #1;
        check("t5_ready_low_disabled", 32'(job_ready), 32'd0);
        pulse_done(8'h15);
        wait_drain("t5_inflight_reports", 20);
        repeat (5) @(negedge clk);
        check("t5_queue_held", 32'(queue_count), 32'd3);
        en = 1'b1;
        expect_launch(0, 8'h1E);
        expect_launch(2, 8'h1F);
        expect_launch(4, 8'h20);
        wait_drain("t5_launch_after_enable", 20);
        check("t5_queue_drained", 32'(queue_count), 32'd0);

        // Reset mid-run with jobs queued and threads running.
        push_job(8'h21, ok);
        push_job(8'h22, ok);
        stop_push();
        check("t6_queued_before_reset", 32'(queue_count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("t6_start_thread", 32'(start_thread), 32'd0);
        check("t6_done_valid", 32'(done_valid), 32'd0);
        check("t6_done_id_thread", 32'({done_thread, done_job_id}), 32'd0);
        check("t6_launch_error", 32'(launch_error), 32'd0);
        check("t6_err_thread", 32'(err_thread), 32'd0);
        check("t6_queue_count", 32'(queue_count), 32'd0);
        check("t6_slots_idle", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_job_ready", 32'(job_ready), 32'd1);
        check("final_queues_empty", 32'(launch_exp_q.size() + done_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
